mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: address/data width.
REQ-002 Parameter TIMEOUT, default 15: max cycles awaiting mem_ack before abort; range 1..255.
REQ-003 clk  in  1: single clock, all state on rising edge.
REQ-004 reset  in  1: asynchronous, active-high.
REQ-005 i_req  in  1: instruction-fetch request; held until i_ready or i_err.
REQ-006 i_addr  in  WIDTH: fetch address; stable while i_req.
REQ-007 i_ready  out  1: one-cycle pulse, fetch complete, rdata valid.
REQ-008 d_req, d_we  in  1 each: data request and write enable; held until d_ready or d_err.
REQ-009 d_addr, d_wdata  in  WIDTH each: data address/write data; stable while d_req.
REQ-010 d_ready  out  1: one-cycle pulse, data access complete.
REQ-011 i_err, d_err  out  1 each: one-cycle pulse, access aborted by timeout.
REQ-012 rdata  out  WIDTH: mem_rdata forwarded; meaningful only with i_ready/d_ready.
REQ-013 mem_req, mem_we  out  1 each: shared memory port request and write enable.
REQ-014 mem_addr, mem_wdata  out  WIDTH each: shared port address/write data.
REQ-015 mem_ack  in  1: memory completion, sampled only while mem_req=1.
REQ-016 mem_rdata  in  WIDTH: read data, valid with mem_ack.
REQ-017 sel  out  1: current owner, 0=fetch, 1=data.

Function
REQ-018 States IDLE, GRANT_I, GRANT_D; state register only, outputs decoded from state.
REQ-019 IDLE: mem_req=0; one requester pending -> its GRANT state next edge; both pending -> requester not served last (round-robin pointer last).
REQ-020 GRANT_x: mem_req=1, sel fixed to x, mem_addr/mem_wdata/mem_we from requester x; mem_we=0 in GRANT_I.
REQ-021 mem_ack=1 in GRANT_x: same cycle x_ready=1, rdata=mem_rdata; next edge -> IDLE, last<=x, wait counter cleared.
REQ-022 Minimum latency: req seen cycle N, mem_req cycle N+1, ready earliest cycle N+1 (zero-wait memory); one IDLE bubble between grants.
REQ-023 Wait counter increments each GRANT cycle without mem_ack; reaching TIMEOUT -> x_err=1 that cycle, mem_req stays 1 that cycle, next edge -> IDLE, last<=x.
REQ-024 mem_ack and timeout same cycle: ack wins, no err.
REQ-025 Requester deasserting req mid-grant: transaction continues to ack/timeout; pulses still generated.
REQ-026 mem_ack in IDLE ignored; no ready pulse.
REQ-027 i_ready, d_ready, i_err, d_err mutually exclusive; never two in one cycle.
REQ-028 Never two grants without an intervening IDLE cycle; owner never changes while mem_req=1.

Reset
REQ-029 reset asserted: immediately state=IDLE, last=data (fetch wins first tie), counter=0.
REQ-030 During/after reset: mem_req=0, mem_we=0, sel=0, all ready/err=0, mem_addr/mem_wdata/rdata don't-care.
REQ-031 Reset mid-grant aborts silently: no ready/err pulse; requester must reissue.

Structure
REQ-032 Package mem_arb_pkg: state enum (IDLE, GRANT_I, GRANT_D), requester enum (REQ_I=0, REQ_D=1), TIMEOUT default constant.
REQ-033 Address and write-data steering via two instances of existing mux2 (WIDTH), select=sel; no other sub-modules.
REQ-034 Wait counter width $clog2(TIMEOUT+1).

Verification
REQ-035 i_req only, addr 0x0000_0040, mem_ack 2 cycles after mem_req, mem_rdata 0x2402_0005 -> sel=0, mem_we=0, i_ready one pulse with rdata 0x2402_0005.
REQ-036 i_req and d_req same cycle after reset (d_we=1, d_addr 0x1000_0000, d_wdata 0xDEAD_BEEF), zero-wait ack -> fetch first, IDLE bubble, then data with mem_we=1, mem_wdata 0xDEAD_BEEF.
REQ-037 Both held continuously, zero-wait ack -> grants alternate I,D,I,D; one ready per 2 cycles.
REQ-038 d_req, mem_ack never -> d_err pulse in TIMEOUT-th grant cycle (15), then IDLE, mem_req=0.
REQ-039 reset asserted during GRANT_D between edges -> mem_req drops same cycle, no d_ready/d_err, next grant after release goes to fetch on tie.
REQ-040 mem_ack on exactly 15th wait cycle -> d_ready=1, d_err=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, requester ids, default timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Ownership states of the shared memory port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  // Requester identity; the value doubles as the sel encoding.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  // Cycles a grant may wait for mem_ack before it is aborted.
  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mux2.sv
// Generic two-input WIDTH-bit multiplexer.
// Latency: combinational.
// Backpressure: none.
// Ports: a (s=0), b (s=1), s select, y output.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory port, round-robin on ties.
// Latency: grant one cycle after request; ready in the same cycle as mem_ack (earliest one cycle after request).
// Backpressure: requesters hold req until a ready/err pulse; grants time out after TIMEOUT cycles without mem_ack.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   i_req/i_addr/i_ready     fetch requester (read only)
//   d_req/d_we/d_addr/d_wdata/d_ready  data requester
//   i_err/d_err              one-cycle abort pulse on timeout
//   rdata                    mem_rdata forwarded, valid with i_ready/d_ready
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  shared memory port
//   sel                      current owner, 0=fetch, 1=data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ready,
  output logic             i_err,
  output logic             d_err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             sel
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  requester_t       last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_hit;
  logic [WIDTH-1:0] zero_w;

  assign zero_w = '0;

  // Reset leaves last=REQ_D so the very first tie goes to fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= REQ_D;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // This grant cycle would be the TIMEOUT-th without an ack. An ack in the
  // same cycle takes precedence, so it is excluded here.
  assign timeout_hit = (state != IDLE) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    sel       = REQ_I;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_err     = 1'b0;
    d_err     = 1'b0;

    case (state)
      IDLE: begin
        // mem_ack is ignored here; only pending requests matter.
        if (i_req && d_req) begin
          state_nxt = (last == REQ_D) ? GRANT_I : GRANT_D;
        end else if (i_req) begin
          state_nxt = GRANT_I;
        end else if (d_req) begin
          state_nxt = GRANT_D;
        end
      end

      GRANT_I: begin
        mem_req = 1'b1;
        sel     = REQ_I;
        // Completion does not look at i_req: a requester that drops mid-grant
        // still receives its pulse.
        if (mem_ack) begin
          i_ready   = 1'b1;
          state_nxt = IDLE;
          last_nxt  = REQ_I;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          i_err     = 1'b1;
          state_nxt = IDLE;
          last_nxt  = REQ_I;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      GRANT_D: begin
        mem_req = 1'b1;
        mem_we  = d_we;
        sel     = REQ_D;
        if (mem_ack) begin
          d_ready   = 1'b1;
          state_nxt = IDLE;
          last_nxt  = REQ_D;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          d_err     = 1'b1;
          state_nxt = IDLE;
          last_nxt  = REQ_D;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rdata = mem_rdata;

  // Fetch never writes, so its write-data leg is tied to zero.
  mux2 #(.WIDTH(WIDTH)) u_addr_mux (
    .a (i_addr),
    .b (d_addr),
    .s (sel),
    .y (mem_addr)
  );

  mux2 #(.WIDTH(WIDTH)) u_wdata_mux (
    .a (zero_w),
    .b (d_wdata),
    .s (sel),
    .y (mem_wdata)
  );

endmodule
